// File: rtl/store_narrow_buffer_pkg.sv
// Shared types for the store narrowing buffer: store size encodings and the
// memory write request carried through the FIFO.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } store_size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

endpackage

// File: rtl/store_narrow_buffer_lane_pack.sv
// Combinational lane packing: replicates store data across byte lanes, builds
// byte enables, word-aligns the address and flags misaligned half/word stores.
module store_lane_pack
  import store_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output mem_req_t    req,
  output logic        misaligned
);

  always_comb begin
    req        = '0;
    misaligned = 1'b0;
    // The emitted address is always word-aligned, so forcing the low address
    // bits of a misaligned half/word is implicit; byte enables ignore them too.
    req.addr   = {addr[31:2], 2'b00};
    case (size)
      SZ_BYTE: begin
        req.wdata = {4{data[7:0]}};
        req.be    = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        misaligned = addr[0];
        req.wdata  = {2{data[15:0]}};
        req.be     = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned = |addr[1:0];
        req.wdata  = data;
        req.be     = '1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer: packs store requests and queues them in a DEPTH-entry
// FIFO toward data memory. Define STORE_MISALIGN_TRAP_EN to drop and flag
// misaligned stores instead of force-aligning them.
module store_narrow_buffer
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        empty,
  output logic        misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  mem_req_t        fifo_mem [DEPTH];
  mem_req_t        pack_req;
  mem_req_t        head;
  logic            misaligned;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            accept;
  logic            push;
  logic            pop;

  store_lane_pack u_lane_pack (
    .addr       (st_addr),
    .data       (st_data),
    .size       (st_size),
    .req        (pack_req),
    .misaligned (misaligned)
  );

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign st_ready  = !full;
  assign mem_valid = !empty;
  assign accept    = st_valid && st_ready;
  assign pop       = mem_valid && mem_ready;

`ifdef STORE_MISALIGN_TRAP_EN
  logic err_q;

  // A misaligned store completes its handshake but is dropped here.
  assign push         = accept && !misaligned;
  assign misalign_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && misaligned;
  end
`else
  assign push         = accept;
  // Misalignment is absorbed by address forcing, so the flag is discarded.
  assign misalign_err = misaligned & 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pack_req;
  end

  assign head      = fifo_mem[rd_ptr];
  assign mem_addr  = empty ? '0 : head.addr;
  assign mem_wdata = empty ? '0 : head.wdata;
  assign mem_be    = empty ? '0 : head.be;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Scoreboard bench for store_narrow_buffer: directed cases plus random traffic
// against a queue-based reference model.
module tb_store_narrow_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;
  logic        misalign_err;

  exp_t sb[$];
  bit   exp_err = 1'b0;
  bit   last_acc = 1'b0;
  int   checks = 0;
  int   errors = 0;

  store_narrow_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .empty        (empty),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: byte lanes via arithmetic on the address offset.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       output exp_t e, output bit mis);
    int unsigned lane;
    lane    = a % 4;
    e.addr  = a - lane;
    if (sz == 2'd0) begin
      e.wdata = (d & 32'hFF) * 32'h01010101;
      e.be    = 4'(1 << lane);
      mis     = 1'b0;
    end else if (sz == 2'd1) begin
      e.wdata = (d & 32'hFFFF) * 32'h00010001;
      e.be    = (lane >= 2) ? 4'd12 : 4'd3;
      mis     = (a % 2) != 0;
    end else begin
      e.wdata = d;
      e.be    = 4'd15;
      mis     = lane != 0;
    end
  endtask

  // One clock: drive after the rising edge, decide acceptance after the
  // monitor has sampled, so the scoreboard only holds entries accepted so far.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit rdy);
    exp_t e;
    bit   mis;
    @(posedge clk);
    #1;
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_size   = sz;
    mem_ready = rdy;
    #6;
    exp_err  = 1'b0;
    last_acc = rst_n && st_valid && st_ready;
    if (last_acc) begin
      model(a, d, sz, e, mis);
`ifdef STORE_MISALIGN_TRAP_EN
      if (mis) exp_err = 1'b1;
      else     sb.push_back(e);
`else
      sb.push_back(e);
`endif
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 2'd0, rdy);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    st_valid = 1'b0;
    sb.delete();
    exp_err  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    int n;
    n = sb.size();
    chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("mem_valid", 32'(mem_valid), 32'(n != 0));
    chk("misalign_err", 32'(misalign_err), 32'(exp_err));
    if (n != 0) begin
      chk("mem_addr", mem_addr, sb[0].addr);
      chk("mem_wdata", mem_wdata, sb[0].wdata);
      chk("mem_be", 32'(mem_be), 32'(sb[0].be));
      if (mem_ready && rst_n) void'(sb.pop_front());
    end else begin
      chk("mem_addr_idle", mem_addr, 32'h0);
      chk("mem_wdata_idle", mem_wdata, 32'h0);
      chk("mem_be_idle", 32'(mem_be), 32'h0);
    end
  end

  initial begin
    int tries;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Byte store into the top lane, half store into the upper half.
    cycle(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd0, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1, 1'b1);
    idle(2, 1'b1);

    // Backpressure: fill, hold the fifth offer, then drain with wrap.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h100 + 32'(4 * i), $urandom, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h110, 32'h5555_AAAA, 2'd2, 1'b0);
    tries = 0;
    do begin
      cycle(1'b1, 32'h110, 32'h5555_AAAA, 2'd2, 1'b1);
      tries++;
    end while (!last_acc && tries < 10);
    chk("fifth_accepted", 32'(last_acc), 32'd1);
    idle(6, 1'b1);

    // Simultaneous push and pop at occupancy two.
    cycle(1'b1, 32'h200, 32'h1111_1111, 2'd2, 1'b0);
    cycle(1'b1, 32'h205, 32'h0000_00C3, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h300 + 32'(2 * i), $urandom, 2'd1, 1'b1);
    idle(4, 1'b1);

    // Misaligned word and half.
    cycle(1'b1, 32'h0000_3001, 32'hCAFE_F00D, 2'd2, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 32'h0000_3003, 32'hCAFE_F00D, 2'd3, 1'b1);
    cycle(1'b1, 32'h0000_4001, 32'h0000_7788, 2'd1, 1'b1);
    idle(3, 1'b1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h500 + 32'(4 * i), $urandom, 2'd2, 1'b0);
    cycle(1'b0, '0, '0, 2'd0, 1'b1);
    do_reset(2);
    idle(3, 1'b1);
    cycle(1'b1, 32'h0000_0601, 32'h0000_0042, 2'd0, 1'b1);
    idle(2, 1'b1);

    // Random traffic with bursts of stall.
    for (int i = 0; i < 1500; i++) begin
      bit v, r;
      v = ($urandom_range(0, 9) < 6);
      r = ((i / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 9) < 6);
      cycle(v, $urandom, $urandom, 2'($urandom_range(0, 3)), r);
    end

    tries = 0;
    while (sb.size() != 0 && tries < 50) begin
      idle(1, 1'b1);
      tries++;
    end
    chk("final_drain", 32'(sb.size()), 32'd0);
    idle(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrow_buffer.md
# store_narrow_buffer

Store-side complement to the load path's sign extension: it narrows a 32-bit register value to a byte, halfword or word store. The block replicates the value across byte lanes and generates byte enables. Requests go into a DEPTH-entry FIFO that drains to data memory over a valid/ready handshake. It sits between the datapath's store issue point and the data-memory write port, so a stalled memory does not require a combinational path back to the core.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  buffer can accept (= not full)
- st_addr  in  32  byte address
- st_data  in  32  register value; low bits used for byte/half
- st_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated data
- mem_be  out  4  byte enables, bit i = byte lane i
- empty  out  1  FIFO empty
- misalign_err  out  1  one-cycle pulse on rejected misaligned store

## Operation
- Accept on st_valid && st_ready; pop on mem_valid && mem_ready.
- Lane packing:
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011
  - word: wdata=d, be=4'b1111
- Misaligned: half with addr[0]=1; word/size 11 with addr[1:0]≠0. Handling is set by the macro (Configuration).
- FIFO: read/write pointers wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits wide.
  - full = (count==DEPTH), empty = (count==0).
- st_ready = !full. No push when full, even if a pop occurs the same cycle; there is no pass-through.
- Simultaneous push and pop when not full: both happen, count unchanged.
- mem_valid = !empty. mem_addr, mem_wdata and mem_be come from the head storage entry and read 0 when empty.
- Outputs hold stable while mem_valid && !mem_ready.
- Reset, including mid-operation, discards all queued entries. The memory sees no partial transfer afterward.

## Timing
- Reset values: st_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, empty=1, misalign_err=0.
- Latency: a request accepted at edge N shows mem_valid=1 in the cycle after edge N, when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- There is no combinational path from st_* to mem_* or from mem_ready to st_ready. Both sides are registered through FIFO state.
- misalign_err is registered: it is high for exactly the cycle after the accepting edge.

## Configuration
- STORE_MISALIGN_TRAP_EN defined:
  - A misaligned request is still handshaken, with st_ready behaving normally.
  - The request is not enqueued.
  - misalign_err pulses once.
- STORE_MISALIGN_TRAP_EN undefined:
  - Address low bits are forced to alignment (half clears addr[0]; word clears addr[1:0]).
  - The request is packed and enqueued normally.
  - misalign_err is tied 0.

## Structure
- Package store_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - struct mem_req_t {addr[31:0], wdata[31:0], be[3:0]}, the FIFO entry type
- Sub-module store_lane_pack: combinational size/addr/data to mem_req_t and misaligned flag. Top level holds FIFO, pointers, counter, error register.

## Test plan
- Byte store: addr=0x1003, data=0x000000A5, size=00, mem_ready=1 → next cycle mem_addr=0x1000, wdata=0xA5A5A5A5, be=1000; empty=1 after pop.
- Half store: addr=0x2002, data=0x1234BEEF, size=01 → wdata=0xBEEFBEEF, be=1100.
- Backpressure: mem_ready=0 while 5 words pushed (DEPTH=4) → st_ready=0 after 4th accept; 5th held. Release mem_ready → entries drain in order, outputs stable while stalled, pointers wrap.
- Simultaneous push/pop at count=2 → count stays 2, order preserved.
- Misaligned word: addr=0x3001:
  - macro defined → misalign_err high 1 cycle, nothing enqueued.
  - macro undefined → mem_addr=0x3000, be=1111.
- rst_n low mid-drain with 3 queued → immediately mem_valid=0, empty=1, st_ready=1. After release, no stale entries appear.
